// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin scheduler: opcodes and FSM states.
// Configuration macro: ALU_PRIO_EN (see alu_rr_scheduler.sv).
package alu_pkg;

  // Operand width of the shared ALU.
  localparam int DW = 8;

  // ALU opcodes.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Scheduler FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU shared by all requesters.
// Carry semantics:
//   ADD : carry-out of the 9-bit sum
//   SUB : borrow (set when a < b), i.e. bit 8 of the 9-bit difference
//   SHL : bit shifted out of a[7]
//   SHR : bit shifted out of a[0]
//   logic ops / NOT : 0
// Operand b is ignored by the unary ops (NOT, SHL, SHR).
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry
);

  // 9-bit working value: bit 8 is the carry/borrow, bits 7:0 the result.
  logic [8:0] wide;

  // Opcode decode into the 9-bit result.
  always_comb begin
    wide = 9'd0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_SHL:  wide = {a, 1'b0};
      OP_SHR:  wide = {a[0], 1'b0, a[7:1]};
      default: wide = 9'd0;
    endcase
  end

  assign result = wide[7:0];
  assign carry  = wide[8];
  assign zero   = (wide[7:0] == 8'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from last_grant+1 (mod N) and grants the first requester
// found. With prio_en set, requester 0 wins outright whenever it requests;
// otherwise it takes part in the rotation like every other requester.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           prio_en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_valid
);

  logic [IDW-1:0] idx;

  // Priority override for requester 0, else rotating first-found search.
  // Offset N wraps back onto last_grant itself, so a lone requester that
  // was granted last time is still served.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (prio_en && req[0]) begin
      grant[0]    = 1'b1;
      grant_valid = 1'b1;
    end else begin
      for (int i = 1; i <= N; i++) begin
        idx = last_grant + IDW'(i);
        if (!grant_valid && req[idx]) begin
          grant[idx]  = 1'b1;
          grant_idx   = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between N requesters.
// A round-robin arbiter picks one request, its operands are registered, the
// ALU evaluates them for one cycle, and the result is returned on a response
// channel tagged with the requester id.
// Optional feature macro: ALU_PRIO_EN -- when defined, requester 0 has strict
// priority and does not advance the round-robin pointer.
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid && ready. On the request side req_ready is one-hot (or zero), is only
// raised for a requester whose req_valid is high, and depends combinationally
// on req_valid and rsp_ready. On the response side rsp_valid and all rsp_*
// fields are registered and are held stable until rsp_ready is seen.
// Latency: grant in cycle T -> rsp_valid high in cycle T+2.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*8-1:0] req_a,
  input  logic [N*8-1:0] req_b,
  input  logic [N*3-1:0] req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [7:0]     rsp_result,
  output logic           rsp_zero,
  output logic           rsp_carry,
  output state_t         dbg_state
);

`ifdef ALU_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  state_t         state;
  logic [IDW-1:0] last_grant;

  // Registered operands of the op currently in the ALU.
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [2:0]     op_op;
  logic [IDW-1:0] op_id;

  // Arbiter outputs.
  logic [N-1:0]   arb_grant;
  logic [IDW-1:0] arb_idx;
  logic           arb_any;

  // Operands of the requester currently winning arbitration.
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  logic [2:0]     sel_op;

  // ALU outputs.
  logic [7:0]     alu_result;
  logic           alu_zero;
  logic           alu_carry;

  // Arbitration window: idle, or the pending response is leaving this cycle.
  logic           arb_en;
  logic           take;

  assign arb_en    = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
  assign take      = arb_en && arb_any;
  assign req_ready = arb_en ? arb_grant : '0;
  assign dbg_state = state;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant),
    .prio_en     (PRIO_EN),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_any)
  );

  // Select the winning requester's operand slices.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_idx == IDW'(i)) begin
        sel_a  = req_a[i*8 +: 8];
        sel_b  = req_b[i*8 +: 8];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_op),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // Scheduler FSM: operand capture, result capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDW'(N - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_op      <= '0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      // A grant latches operands regardless of which state opened the window.
      if (take) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_op <= sel_op;
        op_id <= arb_idx;
        // A priority win for requester 0 leaves the rotation untouched.
        if (!(PRIO_EN && req_valid[0])) begin
          last_grant <= arb_idx;
        end
      end

      case (state)
        S_IDLE: begin
          if (take) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_carry  <= alu_carry;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= take ? S_EXEC : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = 28; // {grant_cycle[15:0], id[1:0], carry, zero, result[7:0]}

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_result;
  logic           rsp_zero;
  logic           rsp_carry;
  state_t         dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  alu_rr_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  logic [EW-1:0] exp_q[$];
  int            grant_log[$];
  int            model_last = N - 1;

  // Returns {carry, zero, result} from plain integer arithmetic.
  function automatic logic [9:0] model_alu(input int a, input int b, input int op);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a * 2; c = a / 128; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    r = r & 255;
    model_alu = {c[0], (r == 0), r[7:0]};
  endfunction

  // Round-robin choice: first valid requester after 'last', wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef ALU_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  logic [EW-1:0] mon_head;
  bit            mon_rv;
  bit            mon_arb;
  logic [N-1:0]  mon_rr;
  int            mon_g;
  logic [9:0]    mon_fl;

  // Cycle monitor: checks response and grant behaviour every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        model_last = N - 1;
      end else begin
        mon_rv   = 0;
        mon_head = '0;
        if (exp_q.size() > 0) begin
          mon_head = exp_q[0];
          mon_rv   = (cyc >= int'(mon_head[27:12]) + 2);
        end
        checks++;
        if (rsp_valid !== mon_rv) begin
          failures++;
          $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, mon_rv);
        end
        if (mon_rv) begin
          checks++;
          if ({rsp_id, rsp_carry, rsp_zero, rsp_result} !== mon_head[11:0]) begin
            failures++;
            $display("FAIL mon_rsp_data cyc=%0d got id=%0d c=%b z=%b r=%h exp id=%0d c=%b z=%b r=%h",
                     cyc, rsp_id, rsp_carry, rsp_zero, rsp_result,
                     mon_head[11:10], mon_head[9], mon_head[8], mon_head[7:0]);
          end
        end
        mon_arb = (exp_q.size() == 0) || (mon_rv && rsp_ready);
        mon_g   = -1;
        mon_rr  = '0;
        if (mon_arb) mon_g = model_pick(req_valid, model_last);
        if (mon_g >= 0) mon_rr[mon_g] = 1'b1;
        checks++;
        if (req_ready !== mon_rr) begin
          failures++;
          $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, mon_rr);
        end
        if (mon_rv && rsp_ready) void'(exp_q.pop_front());
        if (mon_g >= 0) begin
          mon_fl = model_alu(int'(req_a[mon_g*8 +: 8]), int'(req_b[mon_g*8 +: 8]),
                             int'(req_op[mon_g*3 +: 3]));
          exp_q.push_back({cyc[15:0], mon_g[1:0], mon_fl});
          grant_log.push_back(mon_g);
`ifdef ALU_PRIO_EN
          if (!req_valid[0]) model_last = mon_g;
`else
          model_last = mon_g;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    grant_log.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry} !== 13'd0) begin
      failures++;
      $display("FAIL reset_rsp got v=%b id=%0d r=%h z=%b c=%b exp all zero",
               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(0, 8'h0C, 8'h05, OP_ADD);
    req_valid = 4'b0001;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry} !== {1'b1, 2'd0, 8'h11, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp got v=%b id=%0d r=%h z=%b c=%b exp v=1 id=0 r=11 z=0 c=0",
               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry);
    end
  endtask

  task automatic test_flags();
    int         idx_t[6] = '{2, 3, 2, 0, 1, 3};
    logic [7:0] a_t[6]   = '{8'hFF, 8'hCC, 8'h05, 8'h81, 8'h01, 8'h5A};
    logic [7:0] b_t[6]   = '{8'h01, 8'h9E, 8'h07, 8'h44, 8'h77, 8'h5A};
    logic [2:0] op_t[6]  = '{OP_ADD, OP_NOT, OP_SUB, OP_SHL, OP_SHR, OP_XOR};
    logic [7:0] r_t[6]   = '{8'h00, 8'h33, 8'hFE, 8'h02, 8'h00, 8'h00};
    logic       z_t[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       c_t[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      set_req(idx_t[k], a_t[k], b_t[k], op_t[k]);
      req_valid = '0;
      req_valid[idx_t[k]] = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry} !==
          {1'b1, idx_t[k][1:0], r_t[k], z_t[k], c_t[k]}) begin
        failures++;
        $display("FAIL flags_%0d got v=%b id=%0d r=%h z=%b c=%b exp v=1 id=%0d r=%h z=%b c=%b",
                 k, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry,
                 idx_t[k], r_t[k], z_t[k], c_t[k]);
      end
    end
  endtask

  task automatic test_round_robin();
`ifdef ALU_PRIO_EN
    int exp_ids[5] = '{0, 0, 0, 0, 0};
`else
    int exp_ids[5] = '{0, 1, 2, 3, 0};
`endif
    do_reset(2);
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(i));
    end
    req_valid = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    checks++;
    if (grant_log.size() != 5) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grant_log[k] != exp_ids[k]) begin
          failures++;
          $display("FAIL rr_order_%0d got=%0d exp=%0d", k, grant_log[k], exp_ids[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    rsp_ready = 1'b0;
    set_req(0, 8'h30, 8'h0F, OP_SUB);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    set_req(1, 8'h11, 8'h22, OP_OR);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry} !== {1'b1, 2'd0, 8'h21, 1'b0, 1'b0}
          || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL stall_%0d got v=%b id=%0d r=%h z=%b c=%b rdy=%b exp v=1 id=0 r=21 z=0 c=0 rdy=0000",
                 k, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL stall_release_grant got=%b exp=0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 8'h33}) begin
      failures++;
      $display("FAIL stall_second_rsp got v=%b id=%0d r=%h exp v=1 id=1 r=33",
               rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    rsp_ready = 1'b1;
    set_req(1, 8'h44, 8'h11, OP_ADD);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 8'h10, 8'h20, OP_ADD);
    set_req(2, 8'h03, 8'h01, OP_SUB);
    req_valid = 4'b0101;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset got v=%b rdy=%b exp v=0 rdy=0001", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    checks++;
    if (grant_log.size() < 1 || grant_log[0] != 0) begin
      failures++;
      $display("FAIL midreset_first_grant got=%0d exp=0",
               (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_pair();
`ifdef ALU_PRIO_EN
    int exp_ids[4] = '{0, 0, 0, 0};
`else
    int exp_ids[4] = '{0, 2, 0, 2};
`endif
    do_reset(1);
    rsp_ready = 1'b1;
    set_req(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    set_req(2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    req_valid = 4'b0101;
    repeat (8) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    checks++;
    if (grant_log.size() != 4) begin
      failures++;
      $display("FAIL pair_count got=%0d exp=4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] != exp_ids[k]) begin
          failures++;
          $display("FAIL pair_order_%0d got=%0d exp=%0d", k, grant_log[k], exp_ids[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      end
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_flags();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_pair();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
